// File: rtl/ann_input_loader_pkg.sv
// Shared types and defaults for the ANN input loader: FSM state encoding,
// the stream word type and the latched-request record.
package ann_pkg;

    localparam int ANN_IMAGE_SIZE  = 64;
    localparam int ANN_FIRST_LAYER = 16;

    typedef logic [15:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_IMG,
        LOAD_WT,
        DONE,
        WAIT_REQ
    } loader_state_t;

    typedef struct packed {
        logic req;
        logic sel;
    } pend_t;

    // coef_select = 1 restarts from the image, 0 reloads weights only
    function automatic loader_state_t req_target(input logic sel);
        return sel ? LOAD_IMG : LOAD_WT;
    endfunction

endpackage

// File: rtl/ann_input_loader_index_counter.sv
// Wrapping index counter with enable/clear; rollover flags the increment
// out of the all-ones value so counters can be chained.
module loader_index_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         rollover
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign rollover = en && (cnt == '1);

endmodule

// File: rtl/ann_input_loader.sv
// Streams an image and a weight bank into registered buffers for the ANN core
// and services its reload requests. Optional: ANN_LOADER_CHECKSUM_EN.
module ann_input_loader
    import ann_pkg::*;
#(
    parameter int IMAGE_SIZE  = ANN_IMAGE_SIZE,
    parameter int FIRST_LAYER = ANN_FIRST_LAYER
) (
    input  logic  clk,
    input  logic  n_rst,
    input  word_t data_in,
    input  logic  data_valid,
    output logic  data_ready,
    input  logic  request_coef,
    input  logic  coef_select,
    output word_t image   [IMAGE_SIZE],
    output word_t weights [FIRST_LAYER][IMAGE_SIZE],
    output logic  image_weights_loaded,
    output word_t load_checksum
);

    localparam int IW = $clog2(IMAGE_SIZE);
    localparam int RW = $clog2(FIRST_LAYER);

    loader_state_t state, state_next;
    pend_t         pend;

    logic          xfer;
    logic          img_wr, wt_wr, cnt_clr;
    logic [IW-1:0] img_idx, col;
    logic [RW-1:0] row;
    logic          img_roll, col_roll, row_roll;

    assign xfer = data_valid && data_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     state_next = LOAD_IMG;
            LOAD_IMG: if (img_roll) state_next = LOAD_WT;
            LOAD_WT:  if (row_roll) state_next = DONE;
            DONE:     state_next = WAIT_REQ;
            WAIT_REQ: begin
                if (pend.req)
                    state_next = req_target(pend.sel);
                else if (request_coef)
                    state_next = req_target(coef_select);
            end
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        data_ready           = 1'b0;
        image_weights_loaded = 1'b0;
        img_wr               = 1'b0;
        wt_wr                = 1'b0;
        cnt_clr              = 1'b0;
        case (state)
            IDLE:     cnt_clr = 1'b1;
            LOAD_IMG: begin
                data_ready = 1'b1;
                img_wr     = xfer;
            end
            LOAD_WT:  begin
                data_ready = 1'b1;
                wt_wr      = xfer;
            end
            DONE:     image_weights_loaded = 1'b1;
            default:  ;
        endcase
    end

    // Requests seen while busy are held and replayed from WAIT_REQ; the last one wins
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            pend <= '0;
        else if (state == WAIT_REQ)
            pend <= '0;
        else if (request_coef && (state inside {LOAD_IMG, LOAD_WT, DONE}))
            pend <= '{req: 1'b1, sel: coef_select};
    end

    loader_index_counter #(.W(IW)) u_img_cnt (
        .clk      (clk),
        .n_rst    (n_rst),
        .en       (img_wr),
        .clr      (cnt_clr),
        .cnt      (img_idx),
        .rollover (img_roll)
    );

    loader_index_counter #(.W(IW)) u_col_cnt (
        .clk      (clk),
        .n_rst    (n_rst),
        .en       (wt_wr),
        .clr      (cnt_clr),
        .cnt      (col),
        .rollover (col_roll)
    );

    loader_index_counter #(.W(RW)) u_row_cnt (
        .clk      (clk),
        .n_rst    (n_rst),
        .en       (col_roll),
        .clr      (cnt_clr),
        .cnt      (row),
        .rollover (row_roll)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < IMAGE_SIZE; i++)
                image[i] <= '0;
        end else if (img_wr) begin
            image[img_idx] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int r = 0; r < FIRST_LAYER; r++)
                for (int c = 0; c < IMAGE_SIZE; c++)
                    weights[r][c] <= '0;
        end else if (wt_wr) begin
            weights[row][col] <= data_in;
        end
    end

`ifdef ANN_LOADER_CHECKSUM_EN
    word_t csum_acc;
    logic  csum_clr;

    // A fresh load starts from IDLE or WAIT_REQ; the image-to-weight hop keeps the sum
    assign csum_clr = (state == IDLE || state == WAIT_REQ) &&
                      (state_next == LOAD_IMG || state_next == LOAD_WT);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            csum_acc      <= '0;
            load_checksum <= '0;
        end else begin
            if (csum_clr)
                csum_acc <= '0;
            else if (xfer)
                csum_acc <= csum_acc + data_in;
            if (xfer && state_next == DONE)
                load_checksum <= csum_acc + data_in;
        end
    end
`else
    assign load_checksum = '0;
`endif

endmodule

// File: tb/tb_ann_input_loader.sv
// Directed bench for ann_input_loader: a word scoreboard is filled as the
// stream is driven and drained against the buffers when each load completes.
module tb_ann_input_loader;

    localparam int IS = 64;
    localparam int FL = 16;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [15:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic        request_coef = 1'b0;
    logic        coef_select = 1'b0;
    logic [15:0] image   [0:IS-1];
    logic [15:0] weights [0:FL-1][0:IS-1];
    logic        image_weights_loaded;
    logic [15:0] load_checksum;

    ann_input_loader #(.IMAGE_SIZE(IS), .FIRST_LAYER(FL)) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .data_in              (data_in),
        .data_valid           (data_valid),
        .data_ready           (data_ready),
        .request_coef         (request_coef),
        .coef_select          (coef_select),
        .image                (image),
        .weights              (weights),
        .image_weights_loaded (image_weights_loaded),
        .load_checksum        (load_checksum)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    bit          stuck = 1'b0;
    logic [15:0] exp_q [$];

    int cyc = 0;
    int xfer_cnt = 0;
    int pulse_cnt = 0;
    int pulse_xfer = 0;
    int run = 0;
    int max_run = 0;
    bit run_clr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (run_clr) begin
            run     <= 0;
            max_run <= 0;
        end else if (data_valid && data_ready) begin
            run     <= run + 1;
            max_run <= (run + 1 > max_run) ? run + 1 : max_run;
        end else if (!data_ready) begin
            run <= 0;
        end
        if (data_valid && data_ready) xfer_cnt <= xfer_cnt + 1;
        if (image_weights_loaded) begin
            pulse_cnt  <= pulse_cnt + 1;
            pulse_xfer <= xfer_cnt;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one word and returns just after the edge that accepts it
    task automatic send(input logic [15:0] w, input bit push);
        int t;
        if (stuck) return;
        data_in    = w;
        data_valid = 1'b1;
        t = 0;
        while (data_ready !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        if (data_ready !== 1'b1) begin
            stuck = 1'b1;
            chk("ready_timeout", {31'd0, data_ready}, 32'd1);
            data_valid = 1'b0;
            return;
        end
        if (push) exp_q.push_back(w);
        step();
        data_valid = 1'b0;
    endtask

    function automatic logic [15:0] pop();
        if (exp_q.size() == 0) return 16'h0;
        return exp_q.pop_front();
    endfunction

    task automatic check_load(input bit with_img);
        chk("sb_size", exp_q.size(), with_img ? IS + FL * IS : FL * IS);
        if (with_img)
            for (int i = 0; i < IS; i++)
                chk($sformatf("image[%0d]", i), {16'd0, image[i]}, {16'd0, pop()});
        for (int r = 0; r < FL; r++)
            for (int c = 0; c < IS; c++)
                chk($sformatf("weights[%0d][%0d]", r, c), {16'd0, weights[r][c]}, {16'd0, pop()});
        exp_q.delete();
    endtask

    initial begin
        logic [15:0] exp_csum;
        int t0;

        // reset state
        repeat (3) step();
        chk("rst_ready", {31'd0, data_ready}, 32'd0);
        chk("rst_pulse", {31'd0, image_weights_loaded}, 32'd0);
        chk("rst_image0", {16'd0, image[0]}, 32'd0);
        chk("rst_wt_last", {16'd0, weights[FL-1][IS-1]}, 32'd0);
        chk("rst_csum", {16'd0, load_checksum}, 32'd0);
        n_rst = 1'b1;

        // initial frame: image 1..64, weights 0x0100 + (k mod 256)
        for (int i = 0; i < IS; i++) send(16'(i + 1), 1'b1);
        for (int k = 0; k < FL * IS; k++) send(16'h0100 + 16'(k % 256), 1'b1);
        chk("load1_pulse", {31'd0, image_weights_loaded}, 32'd1);
        chk("load1_ready_done", {31'd0, data_ready}, 32'd0);
        chk("load1_image0", {16'd0, image[0]}, 32'd1);
        chk("load1_image63", {16'd0, image[IS-1]}, 32'd64);
        chk("load1_wt_last", {16'd0, weights[FL-1][IS-1]}, 32'h01FF);
        check_load(1'b1);

        // weight-only reload requested in DONE
        request_coef = 1'b1;
        coef_select  = 1'b0;
        run_clr      = 1'b1;
        step();
        request_coef = 1'b0;
        run_clr      = 1'b0;
        chk("load1_pulse_once", pulse_cnt, 32'd1);
        chk("load1_pulse_xfer", pulse_xfer, 32'd1088);
        chk("load1_pulse_width", {31'd0, image_weights_loaded}, 32'd0);
        for (int k = 0; k < FL * IS; k++) send(16'hAAAA, 1'b1);
        chk("reload_pulse", {31'd0, image_weights_loaded}, 32'd1);
        check_load(1'b0);
        for (int i = 0; i < IS; i++)
            chk($sformatf("reload_image[%0d]", i), {16'd0, image[i]}, 32'(i + 1));
        step();
        chk("reload_run", max_run, 32'd1024);
        chk("reload_pulse_cnt", pulse_cnt, 32'd2);

        // new frame with data_valid toggling during the image phase
        request_coef = 1'b1;
        coef_select  = 1'b1;
        step();
        request_coef = 1'b0;
        t0 = 0;
        while (data_ready !== 1'b1 && t0 < 10) begin
            step();
            t0++;
        end
        chk("frame_ready", {31'd0, data_ready}, 32'd1);
        t0 = cyc;
        for (int i = 0; i < IS; i++) begin
            data_valid = 1'b0;
            step();
            send(16'h5000 + 16'(i), 1'b1);
        end
        chk("toggle_cycles", cyc - t0, 32'd128);

        // one-cycle new-frame request midway through the weight phase
        for (int k = 0; k < FL * IS; k++) begin
            if (k == 512) begin
                request_coef = 1'b1;
                coef_select  = 1'b1;
            end
            send(16'h3000 + 16'(k), 1'b1);
            request_coef = 1'b0;
            coef_select  = 1'b0;
        end
        chk("midreq_pulse", {31'd0, image_weights_loaded}, 32'd1);
        check_load(1'b1);
        step();
        chk("midreq_wait_ready", {31'd0, data_ready}, 32'd0);
        step();
        chk("midreq_img_ready", {31'd0, data_ready}, 32'd1);

        // reset after 30 words of an image, then a fresh load
        for (int i = 0; i < 30; i++) send(16'h7000 + 16'(i), 1'b0);
        n_rst = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, data_ready}, 32'd0);
        chk("midrst_pulse", {31'd0, image_weights_loaded}, 32'd0);
        chk("midrst_image0", {16'd0, image[0]}, 32'd0);
        chk("midrst_wt00", {16'd0, weights[0][0]}, 32'd0);
        chk("midrst_csum", {16'd0, load_checksum}, 32'd0);
        step();
        n_rst = 1'b1;
        for (int i = 0; i < IS; i++) send(16'hFFFF, 1'b1);
        for (int k = 0; k < FL * IS; k++) send(16'h0001, 1'b1);
        chk("fresh_pulse", {31'd0, image_weights_loaded}, 32'd1);
        chk("fresh_image29", {16'd0, image[29]}, 32'hFFFF);
`ifdef ANN_LOADER_CHECKSUM_EN
        exp_csum = 16'h03C0;
`else
        exp_csum = 16'h0000;
`endif
        chk("fresh_csum", {16'd0, load_checksum}, {16'd0, exp_csum});
        check_load(1'b1);
        step();
        chk("fresh_pulse_width", {31'd0, image_weights_loaded}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
